// File: rtl/ring_router_mux_rr_n_pkg.sv
// Shared DII flit type for the ring-router round-robin mux.
// Flit = valid + last + 16-bit data.
package ring_router_mux_rr_n_pkg;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/ring_router_mux_rr_n_if.sv
// DII channel: 16-bit data + last with valid/ready handshake.
// master drives valid/last/data, slave drives ready.
interface ring_router_mux_rr_n_if;
  logic        valid;
  logic        last;
  logic [15:0] data;
  logic        ready;

  modport master (
    output valid, last, data,
    input  ready
  );

  modport slave (
    input  valid, last, data,
    output ready
  );
endinterface

// File: rtl/ring_router_mux_rr_n_skid.sv
// Two-entry skid buffer for DII flits; all outputs are flops.
// Ports: clk, rst (sync, low), in_flit/in_ready, out_flit/out_ready.
module ring_router_mux_rr_n_skid
  import ring_router_mux_rr_n_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_flit,
  output logic    in_ready,
  output dii_flit out_flit,
  input  logic    out_ready
);

  dii_flit hd;
  dii_flit sk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hd <= '0;
      sk <= '0;
    end else if (out_ready || !hd.valid) begin
      if (sk.valid) begin
        hd       <= sk;
        sk.valid <= 1'b0;
      end else begin
        hd <= in_flit;
      end
    end else if (!sk.valid) begin
      sk <= in_flit;
    end
  end

  // ready depends only on the skid flop, never on out_ready
  assign in_ready = !sk.valid;
  assign out_flit = hd;

endmodule

// File: rtl/ring_router_mux_rr_n.sv
// Round-robin DII worm mux: NUM_IN inputs onto one output.
// Ports: clk, rst (sync, low), in[NUM_IN], out, grant, locked.
module ring_router_mux_rr_n
  import ring_router_mux_rr_n_pkg::*;
#(
  parameter int NUM_IN  = 2,
  parameter int OUT_REG = 0,
  parameter int IDXW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ring_router_mux_rr_n_if.slave in [NUM_IN],
  ring_router_mux_rr_n_if.master out,
  output logic [IDXW-1:0]       grant,
  output logic                  locked
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WORM
  } state_t;

  // {found, index} of first valid scanning p, p+1, ... wrapped
  function automatic logic [IDXW:0] pick(
    input logic [NUM_IN-1:0] v,
    input logic [IDXW-1:0]   p
  );
    logic [IDXW:0]   r;
    logic [IDXW-1:0] k;
    r = '0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      k = IDXW'((int'(p) + j) % NUM_IN);
      if (v[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  function automatic logic [IDXW-1:0] nxt(
    input logic [IDXW-1:0] x
  );
    return (x == IDXW'(NUM_IN - 1)) ? '0 : x + IDXW'(1);
  endfunction

  logic [NUM_IN-1:0] iv;
  logic [NUM_IN-1:0] il;
  logic [NUM_IN-1:0] rdy;
  logic [15:0]       id [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign iv[i]       = in[i].valid;
    assign il[i]       = in[i].last;
    assign id[i]       = in[i].data;
    assign in[i].ready = rdy[i];
  end

  state_t          state, state_n;
  logic [IDXW-1:0] ptr, ptr_n;
  logic [IDXW-1:0] owner, owner_n;
  logic [IDXW-1:0] sel;
  logic [IDXW:0]   pk;
  logic            con;
  logic            m_ready;
  dii_flit         m;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    pk      = pick(iv, ptr);
    sel     = '0;
    con     = 1'b0;
    unique case (state)
      IDLE: begin
        sel = pk[IDXW-1:0];
        con = pk[IDXW];
      end
      HOLD, WORM: begin
        sel = owner;
        con = 1'b1;
      end
      default: ;
    endcase
    // reset forces every visible output quiet
    m.valid  = con & iv[sel] & rst;
    m.last   = il[sel];
    m.data   = id[sel];
    rdy      = '0;
    rdy[sel] = con & m_ready & rst;
    grant    = rst ? sel : '0;
    locked   = rst & (state != IDLE);
    unique case (state)
      IDLE: begin
        if (con) begin
          owner_n = sel;
          if (!m_ready) state_n = HOLD;
          else if (!m.last) state_n = WORM;
          else ptr_n = nxt(sel);
        end
      end
      HOLD: begin
        if (!iv[owner]) begin
          state_n = IDLE;
        end else if (m_ready) begin
          if (m.last) begin
            state_n = IDLE;
            ptr_n   = nxt(owner);
          end else begin
            state_n = WORM;
          end
        end
      end
      WORM: begin
        if (iv[owner] && m_ready && m.last) begin
          state_n = IDLE;
          ptr_n   = nxt(owner);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    dii_flit q;
    ring_router_mux_rr_n_skid u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_flit  (m),
      .in_ready (m_ready),
      .out_flit (q),
      .out_ready(out.ready)
    );
    assign out.valid = q.valid;
    assign out.last  = q.last;
    assign out.data  = q.data;
  end else begin : g_comb
    assign out.valid = m.valid;
    assign out.last  = m.last;
    assign out.data  = m.data;
    assign m_ready   = out.ready;
  end

endmodule
